eth_ctrl_avmm_bridge: RTL

ETH_CTRL_AVMM_BRIDGE -- requirements
Module: eth_ctrl_avmm_bridge

---
 rtl/eth_ctrl_avmm_bridge.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_ctrl_avmm_bridge.sv
// -----------------------------------------------------------------------------
// eth_ctrl_avmm_bridge
//
// Purpose:
//   Turns a level-held command word into single Avalon-MM transactions towards
//   a MAC CSR block. A request in eth_ctrl_addr starts exactly one write or
//   read. The bridge then parks in HOLD until the requester drops both request
//   bits, so a held command never repeats.
//
// Optional feature (macro ETH_CTRL_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts in-flight cycles. After
//   TIMEOUT_CYCLES cycles it aborts the transaction, sets the sticky ctrl_err
//   flag and, on a read, returns 32'hDEADBEEF. When the macro is undefined,
//   no counter exists, ctrl_err is tied low and the bridge waits indefinitely.
//
// Ports:
//   uClk_usr            in   1   clock
//   pck_cp2af_softReset in   1   asynchronous active-high reset
//   eth_ctrl_addr       in  32   [15:0] CSR word address, [16] write req,
//                                [17] read req, [31:18] unused
//   eth_wr_data         in  32   write data
//   eth_rd_data         out 32   last read result
//   ctrl_busy           out  1   transaction in flight
//   ctrl_err            out  1   sticky timeout flag
//   avm_address         out 16   Avalon-MM address
//   avm_write           out  1   Avalon-MM write strobe
//   avm_read            out  1   Avalon-MM read strobe
//   avm_writedata       out 32   Avalon-MM write data
//   avm_readdata        in  32   Avalon-MM read data
//   avm_readdatavalid   in   1   Avalon-MM read data valid
//   avm_waitrequest     in   1   Avalon-MM wait request
// -----------------------------------------------------------------------------
module eth_ctrl_avmm_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        uClk_usr,
    input  logic        pck_cp2af_softReset,
    input  logic [31:0] eth_ctrl_addr,
    input  logic [31:0] eth_wr_data,
    output logic [31:0] eth_rd_data,
    output logic        ctrl_busy,
    output logic        ctrl_err,
    output logic [15:0] avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD      = 3'd2,
        RD_WAIT = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_data;

    logic w_wr_req;
    logic w_rd_req;
    logic w_accept;
    logic w_busy;
    logic w_capture;
    logic w_timeout;

    // The upper command bits carry no meaning for this block.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^eth_ctrl_addr[31:18];

    // A write wins when both request bits are high.
    assign w_wr_req = eth_ctrl_addr[16];
    assign w_rd_req = eth_ctrl_addr[17] & ~eth_ctrl_addr[16];
    assign w_accept = (r_state == IDLE) && (w_wr_req || w_rd_req);
    assign w_busy   = (r_state == WR) || (r_state == RD) || (r_state == RD_WAIT);

    // Read data is taken either in RD (valid in the same cycle as acceptance)
    // or in RD_WAIT. A valid seen in any other state is ignored.
    assign w_capture = ((r_state == RD) && !avm_waitrequest && avm_readdatavalid) ||
                       ((r_state == RD_WAIT) && avm_readdatavalid);

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops them immediately. Only one of WR/RD can be active.
    assign avm_write     = (r_state == WR);
    assign avm_read      = (r_state == RD);
    assign avm_address   = r_addr;
    assign avm_writedata = r_wdata;
    assign ctrl_busy     = w_busy;
    assign eth_rd_data   = r_rd_data;

`ifdef ETH_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_ctrl_err;
    logic             w_rd_abort;
    logic             w_wr_abort;

    // The count holds the number of busy cycles already elapsed. The abort
    // fires on the TIMEOUT_CYCLES-th busy cycle.
    assign w_timeout  = w_busy && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // A response that arrives on the final cycle still completes normally.
    assign w_rd_abort = w_timeout && ((r_state == RD) || (r_state == RD_WAIT)) && !w_capture;
    assign w_wr_abort = w_timeout && (r_state == WR) && avm_waitrequest;
    assign ctrl_err   = r_ctrl_err;

    always_ff @(posedge uClk_usr or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            r_tmo_cnt  <= '0;
            r_ctrl_err <= 1'b0;
        end else begin
            if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_accept) begin
                r_ctrl_err <= 1'b0;
            end else if (w_rd_abort || w_wr_abort) begin
                r_ctrl_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign ctrl_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge uClk_usr or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_req) begin
                    w_state_next = WR;
                end else if (w_rd_req) begin
                    w_state_next = RD;
                end
            end
            WR: begin
                if (!avm_waitrequest || w_timeout) begin
                    w_state_next = HOLD;
                end
            end
            RD: begin
                if (w_capture || w_timeout) begin
                    w_state_next = HOLD;
                end else if (!avm_waitrequest) begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_capture || w_timeout) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (eth_ctrl_addr[17:16] == 2'b00) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Command latches and the read-result register
    always_ff @(posedge uClk_usr or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= eth_ctrl_addr[15:0];
                if (w_wr_req) begin
                    r_wdata <= eth_wr_data;
                end
            end
            if (w_capture) begin
                r_rd_data <= avm_readdata;
            end
`ifdef ETH_CTRL_TIMEOUT_EN
            else if (w_rd_abort) begin
                r_rd_data <= 32'hDEAD_BEEF;
            end
`endif
        end
    end

endmodule
